// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two byte FIFO with a valid/ready write port.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (even, or odd with PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int DEPTH      = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_BITS-1:0]     in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    generate
        if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
            DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
            $error("uart_tx_fifo: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop;

    state_t               state, state_next;
    logic [CW-1:0]        baud_cnt, cnt_next;
    logic [2:0]           bit_idx, idx_next;
    logic [DATA_BITS-1:0] payload;
    logic                 tx_next, busy_next;
    logic                 baud_done;

    // Full is the only thing that blocks a write; a same-cycle pop never frees a slot early.
    assign in_ready  = (fifo_count != CNTW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign baud_done = (baud_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            payload  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= cnt_next;
            bit_idx  <= idx_next;
            if (pop)
                payload <= mem[rd_ptr];
            tx       <= tx_next;
            busy     <= busy_next;
        end
    end

    // Every state lasts DIV cycles; bit_idx walks data bits in DATA and stop bits in STOP.
    always_comb begin
        state_next = state;
        cnt_next   = baud_done ? '0 : baud_cnt + 1'b1;
        idx_next   = bit_idx;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    idx_next   = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done)
                    state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        idx_next = '0;
                        if (fifo_count != '0) begin
                            pop        = 1'b1;
                            state_next = S_START;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // tx and busy are registered, so they are decoded from where the FSM is heading.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
        case (state_next)
            S_IDLE:   busy_next = 1'b0;
            S_START:  tx_next   = 1'b0;
            S_DATA:   tx_next   = payload[idx_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next   = (^payload) ^ (PARITY_ODD != 0);
`endif
            S_STOP:   tx_next   = 1'b1;
            default:  busy_next = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model, line receiver and directed scenarios.
// Parity expectations follow UART_TX_PARITY_EN when the bench is built with that macro.
module tb_uart_tx_fifo;

    localparam int CLK_HZ    = 1000;
    localparam int BAUD      = 100;
    localparam int DIV       = CLK_HZ / BAUD;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int DEPTH     = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS     = 1;
    localparam int EXP_FRAME = 110;
`else
    localparam int PBITS     = 0;
    localparam int EXP_FRAME = 100;
`endif
    localparam int NBITS     = 1 + DATA_BITS + PBITS + STOP_BITS;
    localparam int FRAME_LEN = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS), .DEPTH(DEPTH), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are held across the next one.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        rst = r;
        in_valid = v;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input int bound);
        for (int n = 0; n < bound; n++) begin
            if (!busy && fifo_count == 4'd0)
                break;
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
        checkOutput("reached_idle", busy, 1'b0);
    endtask

    // Reference model: queue of accepted bytes and a frame position counter.
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_acc;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0)
            return 1'b0;
        if (k <= DATA_BITS)
            return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == DATA_BITS + 1)
            return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_pos = 0;
        end else begin
            m_acc = in_valid && (mq.size() < DEPTH);
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME_LEN)
                    m_active = 1'b0;
            end
            if (!m_active && mq.size() > 0) begin
                m_byte = mq.pop_front();
                m_active = 1'b1;
                m_pos = 0;
            end
            if (m_acc)
                mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_tx", tx, m_active ? frame_bit(m_byte, m_pos / DIV) : 1'b1);
            checkOutput("model_busy", busy, m_active);
            checkOutput("model_fifo_count", fifo_count, mq.size());
            checkOutput("model_in_ready", in_ready, mq.size() != DEPTH);
        end
    end

    // Line receiver sampling mid-bit, plus busy span monitors.
    int         rx_phase = -1;
    int         rx_k;
    logic [7:0] rx_shift = 8'h00;
    logic       rx_par = 1'b0;
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    int         cyc = 0;
    int         busy_cycles = 0;
    int         first_busy = -1;
    int         last_busy = -1;
    int         full_blocked = 0;

    always @(negedge clk) begin
        cyc++;
        if (busy) begin
            busy_cycles++;
            if (first_busy < 0)
                first_busy = cyc;
            last_busy = cyc;
        end
        if (fifo_count == 4'd8 && in_valid && !in_ready)
            full_blocked++;
        if (rst) begin
            rx_phase = -1;
        end else if (rx_phase < 0) begin
            if (tx === 1'b0)
                rx_phase = 0;
        end else begin
            rx_phase++;
            if (rx_phase % DIV == DIV / 2) begin
                rx_k = rx_phase / DIV;
                if (rx_k >= 1 && rx_k <= DATA_BITS)
                    rx_shift[rx_k-1] = tx;
`ifdef UART_TX_PARITY_EN
                else if (rx_k == DATA_BITS + 1)
                    rx_par = tx;
`endif
                else if (rx_k == NBITS - STOP_BITS) begin
                    checkOutput("rx_stop_bit", tx, 1'b1);
                    rx_q.push_back(rx_shift);
                    rx_par_q.push_back(rx_par);
                    rx_phase = -1;
                end
            end
        end
    end

    task automatic clearMonitors();
        rx_q.delete();
        rx_par_q.delete();
        busy_cycles = 0;
        first_busy = -1;
        last_busy = -1;
        full_blocked = 0;
    endtask

    string      hello = "Hello World";
`ifdef UART_TX_PARITY_EN
    logic [10:0] line48 = 11'b1_0_01001000_0;
`else
    logic [9:0]  line48 = 10'b1_01001000_0;
`endif
    logic [7:0] par_bytes [2] = '{8'h07, 8'h03};
    logic       par_exp [2] = '{1'b1, 1'b0};
    bit         acc;
    int         g;

    initial begin
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        check_en = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

        $display("[TB] reset while idle");
        applyStimulus(1'b1, 1'b1, 8'h33);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_fifo_count", fifo_count, 4'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

        $display("[TB] single byte 0x48");
        clearMonitors();
        applyStimulus(1'b0, 1'b1, 8'h48);
        for (int c = 0; c < FRAME_LEN + 10; c++) begin
            applyStimulus(1'b0, 1'b0, 8'hFF);
            if (c < FRAME_LEN && (c % DIV == 0 || c % DIV == DIV - 1))
                checkOutput("line_0x48", tx, line48[c / DIV]);
        end
        checkOutput("busy_len_0x48", busy_cycles, EXP_FRAME);
        checkOutput("after_frame_tx", tx, 1'b1);
        checkOutput("rx_count_0x48", rx_q.size(), 1);
        checkOutput("rx_byte_0x48", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h48);

        $display("[TB] Hello World burst");
        clearMonitors();
        for (int i = 0; i < hello.len(); i++) begin
            for (g = 0; g < 2000; g++) begin
                acc = in_ready;
                applyStimulus(1'b0, 1'b1, hello[i]);
                if (acc)
                    break;
            end
        end
        waitIdle(3000);
        checkOutput("hello_full_seen", full_blocked > 0, 1'b1);
        checkOutput("hello_busy_cycles", busy_cycles, 11 * EXP_FRAME);
        checkOutput("hello_no_gap_span", last_busy - first_busy + 1, 11 * EXP_FRAME);
        checkOutput("hello_rx_count", rx_q.size(), 11);
        for (int i = 0; i < rx_q.size() && i < hello.len(); i++)
            checkOutput("hello_rx_byte", rx_q[i], hello[i]);

        $display("[TB] push while full");
        clearMonitors();
        applyStimulus(1'b0, 1'b1, 8'h11);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b1, 8'h21 + 8'(i));
        checkOutput("full_count", fifo_count, 4'd8);
        for (int i = 0; i < 5; i++) begin
            checkOutput("full_in_ready", in_ready, 1'b0);
            applyStimulus(1'b0, 1'b1, 8'hAA);
            checkOutput("full_count_hold", fifo_count, 4'd8);
        end
        waitIdle(2000);
        checkOutput("full_rx_count", rx_q.size(), 9);
        for (int i = 0; i < rx_q.size() && i < 9; i++)
            checkOutput("full_rx_byte", rx_q[i], (i == 0) ? 8'h11 : 8'h20 + 8'(i));

        $display("[TB] reset mid-frame");
        clearMonitors();
        applyStimulus(1'b0, 1'b1, 8'h55);
        applyStimulus(1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h02);
        applyStimulus(1'b0, 1'b1, 8'h03);
        repeat (42) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("pre_rst_count", fifo_count, 4'd3);
        checkOutput("pre_rst_busy", busy, 1'b1);
        checkOutput("pre_rst_bit3", tx, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("mid_rst_tx", tx, 1'b1);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_count", fifo_count, 4'd0);
        repeat (5) applyStimulus(1'b0, 1'b0, 8'h00);
        clearMonitors();
        applyStimulus(1'b0, 1'b1, 8'h0F);
        waitIdle(500);
        checkOutput("post_rst_rx_count", rx_q.size(), 1);
        checkOutput("post_rst_rx_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h0F);
        checkOutput("post_rst_frame_len", busy_cycles, EXP_FRAME);

        $display("[TB] frame length and parity");
        for (int i = 0; i < 2; i++) begin
            repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
            clearMonitors();
            applyStimulus(1'b0, 1'b1, par_bytes[i]);
            waitIdle(500);
            checkOutput("frame_len", busy_cycles, EXP_FRAME);
            checkOutput("frame_rx_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, par_bytes[i]);
`ifdef UART_TX_PARITY_EN
            checkOutput("parity_bit", (rx_par_q.size() > 0) ? rx_par_q[0] : 1'bx, par_exp[i]);
`endif
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
